// File: rtl/im_fetch_responder.sv
// Instruction-memory responder for the PC fetch port: one-cycle registered fetch,
// stall hold, flush-to-NOP and an always-live loader write port.
module im_fetch_responder #(
    parameter int          ADDR_W   = 14,
    parameter int          DEPTH    = 16384,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] IM_address,
    input  logic              IM_read_en,
    input  logic              flush,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic [31:0]       inst_out,
    output logic              inst_valid,
    output logic              addr_err,
    output logic [1:0]        state_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] inst_q;
    logic        valid_q;
    logic        err_q;
    logic        capture;
    logic        squash;
    logic        fetch_in_range;
    logic        load_in_range;
    logic [31:0] mem [DEPTH];

    // Range checks widened to 32 bits so DEPTH may be smaller than 2**ADDR_W.
    assign fetch_in_range = ({{(32-ADDR_W){1'b0}}, IM_address} < 32'(DEPTH));
    assign load_in_range  = ({{(32-ADDR_W){1'b0}}, load_addr}  < 32'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // capture: latch a new word; squash: replace output with a NOP bubble.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        squash  = 1'b0;
        case (state_q)
            BOOT: begin
                if (IM_read_en) begin
                    capture = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (flush) begin
                    squash = 1'b1;
                end else if (IM_read_en) begin
                    capture = 1'b1;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (flush) begin
                    squash  = 1'b1;
                    state_d = FETCH;
                end else if (IM_read_en) begin
                    capture = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // Loader port has no reset term so programs can be written while rst is high.
    always_ff @(posedge clk) begin
        if (load_we && load_in_range) begin
            mem[load_addr[IDX_W-1:0]] <= load_data;
        end
    end

    // Old contents are read here in the same edge a loader write lands: read-before-write.
    always_ff @(posedge clk) begin
        if (rst || squash) begin
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (capture) begin
            valid_q <= 1'b1;
            if (fetch_in_range) begin
                inst_q <= mem[IM_address[IDX_W-1:0]];
                err_q  <= 1'b0;
            end else begin
                inst_q <= NOP_INST;
                err_q  <= 1'b1;
            end
        end
    end

    assign inst_out   = inst_q;
    assign inst_valid = valid_q;
    assign addr_err   = err_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_im_fetch_responder.sv
// Directed bench for im_fetch_responder with a small memory (DEPTH=16).
module tb_im_fetch_responder;

    localparam int ADDR_W = 14;
    localparam int DEPTH  = 16;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] IM_address;
    logic              IM_read_en;
    logic              flush;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic [31:0]       inst_out;
    logic              inst_valid;
    logic              addr_err;
    logic [1:0]        state_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_inst;
    logic        exp_valid;
    logic        exp_err;
    logic [1:0]  exp_st;

    im_fetch_responder #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .NOP_INST(32'h0000_0013)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .IM_address(IM_address),
        .IM_read_en(IM_read_en),
        .flush     (flush),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .inst_out  (inst_out),
        .inst_valid(inst_valid),
        .addr_err  (addr_err),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic [31:0] i, input logic v, input logic e, input logic [1:0] s);
        exp_inst  = i;
        exp_valid = v;
        exp_err   = e;
        exp_st    = s;
    endtask

    task automatic test_reset();
        rst = 1'b1; IM_address = '0; IM_read_en = 1'b0; flush = 1'b0;
        load_we = 1'b0; load_addr = '0; load_data = '0;
        tick();
        tick();
        set_exp(32'h13, 1'b0, 1'b0, 2'd0);
        checks++;
        if ({inst_out, inst_valid, addr_err, state_o} !== {exp_inst, exp_valid, exp_err, exp_st}) begin
            errors++;
            $display("FAIL reset: got inst=%h v=%b e=%b st=%0d want inst=%h v=%b e=%b st=%0d",
                     inst_out, inst_valid, addr_err, state_o, exp_inst, exp_valid, exp_err, exp_st);
        end
        rst = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if ({inst_out, inst_valid, addr_err, state_o} !== {exp_inst, exp_valid, exp_err, exp_st}) begin
            errors++;
            $display("FAIL boot_flush_ignored: got inst=%h v=%b e=%b st=%0d want inst=%h v=%b e=%b st=%0d",
                     inst_out, inst_valid, addr_err, state_o, exp_inst, exp_valid, exp_err, exp_st);
        end
    endtask

    task automatic test_load();
        logic [31:0] words [5];
        logic [ADDR_W-1:0] addrs [5];
        words = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hAF};
        addrs = '{14'd0, 14'd1, 14'd2, 14'd3, 14'd15};
        for (int i = 0; i < 5; i++) begin
            load_we = 1'b1; load_addr = addrs[i]; load_data = words[i];
            tick();
        end
        load_we = 1'b0;
        checks++;
        if ({inst_valid, state_o} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL load_in_boot: got v=%b st=%0d want v=0 st=0", inst_valid, state_o);
        end
    endtask

    task automatic test_fetch();
        logic [31:0] want [3];
        want = '{32'hA0, 32'hA1, 32'hA2};
        for (int i = 0; i < 3; i++) begin
            IM_address = ADDR_W'(i); IM_read_en = 1'b1;
            tick();
            set_exp(want[i], 1'b1, 1'b0, 2'd1);
            checks++;
            if ({inst_out, inst_valid, addr_err, state_o} !== {exp_inst, exp_valid, exp_err, exp_st}) begin
                errors++;
                $display("FAIL fetch_%0d: got inst=%h v=%b e=%b st=%0d want inst=%h v=%b e=%b st=%0d", i,
                         inst_out, inst_valid, addr_err, state_o, exp_inst, exp_valid, exp_err, exp_st);
            end
        end
    endtask

    task automatic test_hold();
        IM_address = 14'd1; IM_read_en = 1'b1;
        tick();
        IM_address = 14'd3; IM_read_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            set_exp(32'hA1, 1'b1, 1'b0, 2'd2);
            checks++;
            if ({inst_out, inst_valid, addr_err, state_o} !== {exp_inst, exp_valid, exp_err, exp_st}) begin
                errors++;
                $display("FAIL hold_%0d: got inst=%h v=%b e=%b st=%0d want inst=%h v=%b e=%b st=%0d", i,
                         inst_out, inst_valid, addr_err, state_o, exp_inst, exp_valid, exp_err, exp_st);
            end
        end
        IM_read_en = 1'b1;
        tick();
        set_exp(32'hA3, 1'b1, 1'b0, 2'd1);
        checks++;
        if ({inst_out, inst_valid, addr_err, state_o} !== {exp_inst, exp_valid, exp_err, exp_st}) begin
            errors++;
            $display("FAIL hold_release: got inst=%h v=%b e=%b st=%0d want inst=%h v=%b e=%b st=%0d",
                     inst_out, inst_valid, addr_err, state_o, exp_inst, exp_valid, exp_err, exp_st);
        end
    endtask

    task automatic test_flush();
        IM_address = 14'd2; IM_read_en = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        set_exp(32'h13, 1'b0, 1'b0, 2'd1);
        checks++;
        if ({inst_out, inst_valid, addr_err, state_o} !== {exp_inst, exp_valid, exp_err, exp_st}) begin
            errors++;
            $display("FAIL flush_fetch: got inst=%h v=%b e=%b st=%0d want inst=%h v=%b e=%b st=%0d",
                     inst_out, inst_valid, addr_err, state_o, exp_inst, exp_valid, exp_err, exp_st);
        end
        tick();
        set_exp(32'hA2, 1'b1, 1'b0, 2'd1);
        checks++;
        if ({inst_out, inst_valid, addr_err, state_o} !== {exp_inst, exp_valid, exp_err, exp_st}) begin
            errors++;
            $display("FAIL after_flush: got inst=%h v=%b e=%b st=%0d want inst=%h v=%b e=%b st=%0d",
                     inst_out, inst_valid, addr_err, state_o, exp_inst, exp_valid, exp_err, exp_st);
        end
        // Flush while stalled must leave HOLD.
        IM_read_en = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_exp(32'h13, 1'b0, 1'b0, 2'd1);
        checks++;
        if ({inst_out, inst_valid, addr_err, state_o} !== {exp_inst, exp_valid, exp_err, exp_st}) begin
            errors++;
            $display("FAIL flush_hold: got inst=%h v=%b e=%b st=%0d want inst=%h v=%b e=%b st=%0d",
                     inst_out, inst_valid, addr_err, state_o, exp_inst, exp_valid, exp_err, exp_st);
        end
    endtask

    task automatic test_out_of_range();
        logic [ADDR_W-1:0] a [4];
        logic [31:0]       wi [4];
        logic              we [4];
        a  = '{14'd20, 14'd0, 14'd16, 14'd15};
        wi = '{32'h13, 32'hA0, 32'h13, 32'hAF};
        we = '{1'b1, 1'b0, 1'b1, 1'b0};
        IM_read_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            IM_address = a[i];
            tick();
            set_exp(wi[i], 1'b1, we[i], 2'd1);
            checks++;
            if ({inst_out, inst_valid, addr_err, state_o} !== {exp_inst, exp_valid, exp_err, exp_st}) begin
                errors++;
                $display("FAIL range_addr%0d: got inst=%h v=%b e=%b st=%0d want inst=%h v=%b e=%b st=%0d", a[i],
                         inst_out, inst_valid, addr_err, state_o, exp_inst, exp_valid, exp_err, exp_st);
            end
        end
        // An out-of-range load must not alias onto word 0.
        load_we = 1'b1; load_addr = 14'd16; load_data = 32'hDEAD;
        IM_address = 14'd3;
        tick();
        load_we = 1'b0; IM_address = 14'd0;
        tick();
        set_exp(32'hA0, 1'b1, 1'b0, 2'd1);
        checks++;
        if ({inst_out, inst_valid, addr_err, state_o} !== {exp_inst, exp_valid, exp_err, exp_st}) begin
            errors++;
            $display("FAIL load_dropped: got inst=%h v=%b e=%b st=%0d want inst=%h v=%b e=%b st=%0d",
                     inst_out, inst_valid, addr_err, state_o, exp_inst, exp_valid, exp_err, exp_st);
        end
    endtask

    task automatic test_read_before_write();
        IM_address = 14'd1; IM_read_en = 1'b1;
        load_we = 1'b1; load_addr = 14'd1; load_data = 32'h0000_BEEF;
        tick();
        load_we = 1'b0;
        set_exp(32'hA1, 1'b1, 1'b0, 2'd1);
        checks++;
        if ({inst_out, inst_valid, addr_err, state_o} !== {exp_inst, exp_valid, exp_err, exp_st}) begin
            errors++;
            $display("FAIL rbw_old: got inst=%h v=%b e=%b st=%0d want inst=%h v=%b e=%b st=%0d",
                     inst_out, inst_valid, addr_err, state_o, exp_inst, exp_valid, exp_err, exp_st);
        end
        tick();
        set_exp(32'h0000_BEEF, 1'b1, 1'b0, 2'd1);
        checks++;
        if ({inst_out, inst_valid, addr_err, state_o} !== {exp_inst, exp_valid, exp_err, exp_st}) begin
            errors++;
            $display("FAIL rbw_new: got inst=%h v=%b e=%b st=%0d want inst=%h v=%b e=%b st=%0d",
                     inst_out, inst_valid, addr_err, state_o, exp_inst, exp_valid, exp_err, exp_st);
        end
    endtask

    task automatic test_reset_in_hold();
        IM_read_en = 1'b0;
        tick();
        rst = 1'b1; flush = 1'b1;
        load_we = 1'b1; load_addr = 14'd2; load_data = 32'hC2;
        tick();
        rst = 1'b0; flush = 1'b0; load_we = 1'b0;
        set_exp(32'h13, 1'b0, 1'b0, 2'd0);
        checks++;
        if ({inst_out, inst_valid, addr_err, state_o} !== {exp_inst, exp_valid, exp_err, exp_st}) begin
            errors++;
            $display("FAIL reset_hold: got inst=%h v=%b e=%b st=%0d want inst=%h v=%b e=%b st=%0d",
                     inst_out, inst_valid, addr_err, state_o, exp_inst, exp_valid, exp_err, exp_st);
        end
        IM_address = 14'd1; IM_read_en = 1'b1;
        tick();
        set_exp(32'h0000_BEEF, 1'b1, 1'b0, 2'd1);
        checks++;
        if ({inst_out, inst_valid, addr_err, state_o} !== {exp_inst, exp_valid, exp_err, exp_st}) begin
            errors++;
            $display("FAIL mem_retained: got inst=%h v=%b e=%b st=%0d want inst=%h v=%b e=%b st=%0d",
                     inst_out, inst_valid, addr_err, state_o, exp_inst, exp_valid, exp_err, exp_st);
        end
        IM_address = 14'd2;
        tick();
        set_exp(32'hC2, 1'b1, 1'b0, 2'd1);
        checks++;
        if ({inst_out, inst_valid, addr_err, state_o} !== {exp_inst, exp_valid, exp_err, exp_st}) begin
            errors++;
            $display("FAIL load_in_rst: got inst=%h v=%b e=%b st=%0d want inst=%h v=%b e=%b st=%0d",
                     inst_out, inst_valid, addr_err, state_o, exp_inst, exp_valid, exp_err, exp_st);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_fetch();
        test_hold();
        test_flush();
        test_out_of_range();
        test_read_before_write();
        test_reset_in_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
